// File: rtl/mem_ram_param.sv
// Parametrised single-port synchronous RAM with byte enables, registered read and a hardware clear sequencer.
// Optional per-byte even parity with a bit-flip injection hook is enabled by defining MEM_RAM_PARITY_EN.
module mem_ram_param #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH),
    parameter int BE_W   = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              en_wr,
    input  logic              en_rd,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] d_in,
    input  logic [BE_W-1:0]   be,
    output logic [DATA_W-1:0] d_out,
    output logic              rd_valid,
    output logic              busy,
    output logic              addr_err,
    output logic              par_err
);

    typedef enum logic {CLEAR, IDLE} state_t;

    localparam logic [ADDR_W-1:0] PTR_LAST = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   DEPTH_X  = (ADDR_W + 1)'(DEPTH);

    state_t            state;
    logic [ADDR_W-1:0] ptr;
    logic [DATA_W-1:0] mem [DEPTH];
    logic              accept;
    logic              in_range;
    logic              do_wr;
    logic              do_rd;

    // Requests are only honoured in IDLE and never on the edge that samples clr.
    assign accept   = (state == IDLE) && !clr;
    assign in_range = {1'b0, addr} < DEPTH_X;
    assign do_wr    = accept && en_wr && in_range;
    assign do_rd    = accept && en_rd;

`ifdef MEM_RAM_PARITY_EN
    logic [BE_W-1:0] par_mem [DEPTH];
    bit                        flip_tgl;
    bit                        flip_seen;
    bit [ADDR_W-1:0]           flip_a;
    bit [$clog2(DATA_W)-1:0]   flip_b;

    function automatic logic [BE_W-1:0] byte_parity(input logic [DATA_W-1:0] w);
        logic [BE_W-1:0] p;
        for (int i = 0; i < BE_W; i++) p[i] = ^w[8*i +: 8];
        return p;
    endfunction

    // Test hook reached only by hierarchical call: flips one stored data bit on the next clock edge.
    task automatic inject_flip(input logic [ADDR_W-1:0] a, input logic [$clog2(DATA_W)-1:0] b);
        flip_a   = a;
        flip_b   = b;
        flip_tgl = ~flip_tgl;
    endtask
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= CLEAR;
            ptr   <= '0;
            busy  <= 1'b1;
        end else begin
            case (state)
                CLEAR: begin
                    ptr <= ptr + ADDR_W'(1);
                    if (ptr == PTR_LAST) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        ptr   <= '0;
                    end
                end
                IDLE: begin
                    if (clr) begin
                        state <= CLEAR;
                        ptr   <= '0;
                        busy  <= 1'b1;
                    end
                end
                default: begin
                    state <= CLEAR;
                    ptr   <= '0;
                    busy  <= 1'b1;
                end
            endcase
        end
    end

    // Array write port: clear sequencer has priority, then byte-enabled writes.
    always_ff @(posedge clk) begin
        if (state == CLEAR) begin
            mem[ptr] <= '0;
`ifdef MEM_RAM_PARITY_EN
            par_mem[ptr] <= '0;
`endif
        end else if (do_wr) begin
            for (int i = 0; i < BE_W; i++) begin
                if (be[i]) begin
                    mem[addr][8*i +: 8] <= d_in[8*i +: 8];
`ifdef MEM_RAM_PARITY_EN
                    par_mem[addr][i] <= ^d_in[8*i +: 8];
`endif
                end
            end
        end
`ifdef MEM_RAM_PARITY_EN
        if (flip_tgl != flip_seen) begin
            flip_seen            <= flip_tgl;
            mem[flip_a][flip_b]  <= ~mem[flip_a][flip_b];
        end
`endif
    end

    // Read port: array sampled before this edge's write, giving read-before-write.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            d_out    <= '0;
            rd_valid <= 1'b0;
            addr_err <= 1'b0;
            par_err  <= 1'b0;
        end else begin
            rd_valid <= do_rd;
            addr_err <= accept && (en_wr || en_rd) && !in_range;
            if (do_rd) d_out <= in_range ? mem[addr] : '0;
`ifdef MEM_RAM_PARITY_EN
            par_err <= do_rd && in_range && (byte_parity(mem[addr]) != par_mem[addr]);
`else
            par_err <= 1'b0;
`endif
        end
    end

endmodule

// File: tb/tb_mem_ram_param.sv
// Self-checking bench for mem_ram_param: DEPTH=16 and DEPTH=12 instances share stimulus and are
// compared every cycle against a behavioural model, plus literal expectations for key scenarios.
module tb_mem_ram_param;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clr = 1'b0;
    logic        en_wr = 1'b0;
    logic        en_rd = 1'b0;
    logic [3:0]  addr = '0;
    logic [31:0] d_in = '0;
    logic [3:0]  be = '0;

    logic [31:0] d_out_w [2];
    logic        rv_w [2];
    logic        busy_w [2];
    logic        ae_w [2];
    logic        pe_w [2];

    int n_cmp = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;
    int dep [2] = '{16, 12};

    always #5 clk = ~clk;

    mem_ram_param #(.DATA_W(32), .DEPTH(16)) u16 (
        .clk(clk), .rst(rst), .clr(clr), .en_wr(en_wr), .en_rd(en_rd), .addr(addr),
        .d_in(d_in), .be(be), .d_out(d_out_w[0]), .rd_valid(rv_w[0]), .busy(busy_w[0]),
        .addr_err(ae_w[0]), .par_err(pe_w[0]));

    mem_ram_param #(.DATA_W(32), .DEPTH(12)) u12 (
        .clk(clk), .rst(rst), .clr(clr), .en_wr(en_wr), .en_rd(en_rd), .addr(addr),
        .d_in(d_in), .be(be), .d_out(d_out_w[1]), .rd_valid(rv_w[1]), .busy(busy_w[1]),
        .addr_err(ae_w[1]), .par_err(pe_w[1]));

    // Behavioural model: clear is a countdown of remaining busy cycles, contents an array per instance.
    logic [31:0] m_mem [2][16];
    logic [3:0]  m_bad [2][16];
    int          rem [2];
    logic [31:0] e_do [2];
    logic        e_rv [2], e_busy [2], e_ae [2], e_pe [2];

    task automatic model_wipe(input int k);
        for (int a = 0; a < 16; a++) begin
            m_mem[k][a] = '0;
            m_bad[k][a] = '0;
        end
    endtask

    always @(posedge clk or negedge rst) begin
        for (int k = 0; k < 2; k++) begin
            if (!rst) begin
                rem[k] = dep[k];
                e_do[k] = '0; e_rv[k] = 1'b0; e_ae[k] = 1'b0; e_pe[k] = 1'b0; e_busy[k] = 1'b1;
                model_wipe(k);
            end else begin
                bit acc;
                acc = (rem[k] == 0) && !clr;
                e_rv[k] = acc && en_rd;
                e_ae[k] = acc && (en_rd || en_wr) && (int'(addr) >= dep[k]);
                e_pe[k] = 1'b0;
                if (e_rv[k]) begin
                    if (int'(addr) < dep[k]) begin
                        e_do[k] = m_mem[k][addr];
                        e_pe[k] = |m_bad[k][addr];
                    end else begin
                        e_do[k] = '0;
                    end
                end
                if (acc && en_wr && int'(addr) < dep[k]) begin
                    for (int i = 0; i < 4; i++) begin
                        if (be[i]) begin
                            m_mem[k][addr][8*i +: 8] = d_in[8*i +: 8];
                            m_bad[k][addr][i] = 1'b0;
                        end
                    end
                end
                if (rem[k] > 0) rem[k]--;
                else if (clr) begin
                    rem[k] = dep[k];
                    model_wipe(k);
                end
                e_busy[k] = rem[k] > 0;
            end
        end
    end

    task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s [DEPTH=%0d] actual=%h required=%h at t=%0t", nm, dep[k], act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < 2; k++) begin
                chk("d_out", k, d_out_w[k], e_do[k]);
                chk("rd_valid", k, 32'(rv_w[k]), 32'(e_rv[k]));
                chk("busy", k, 32'(busy_w[k]), 32'(e_busy[k]));
                chk("addr_err", k, 32'(ae_w[k]), 32'(e_ae[k]));
                chk("par_err", k, 32'(pe_w[k]), 32'(e_pe[k]));
            end
        end
    end

    task automatic op(input logic w, input logic r, input logic [3:0] a, input logic [31:0] d,
                      input logic [3:0] b);
        @(negedge clk);
        en_wr = w; en_rd = r; addr = a; d_in = d; be = b;
        @(negedge clk);
        en_wr = 1'b0; en_rd = 1'b0;
    endtask

    task automatic busy_count(input int exp16, input int exp12);
        int c16, c12;
        @(negedge clk);
        #2 rst = 1'b1;
        #1 c16 = int'(busy_w[0]); c12 = int'(busy_w[1]);
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            c16 += int'(busy_w[0]);
            c12 += int'(busy_w[1]);
        end
        chk("busy_cycles", 0, 32'(c16), 32'(exp16));
        chk("busy_cycles", 1, 32'(c12), 32'(exp12));
    endtask

    task automatic sweep();
        @(negedge clk);
        en_rd = 1'b1; addr = 4'd0;
        for (int a = 1; a < 16; a++) begin
            @(negedge clk);
            chk("sweep_rd_valid", 0, 32'(rv_w[0]), 32'd1);
            addr = 4'(a);
        end
        @(negedge clk);
        chk("sweep_rd_valid", 0, 32'(rv_w[0]), 32'd1);
        en_rd = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        #2 rst = 1'b0;
        chk_en = 1'b1;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("reset_busy", k, 32'(busy_w[k]), 32'd1);
            chk("reset_d_out", k, d_out_w[k], 32'd0);
            chk("reset_rd_valid", k, 32'(rv_w[k]), 32'd0);
            chk("reset_addr_err", k, 32'(ae_w[k]), 32'd0);
        end
        busy_count(16, 12);

        // All locations read back zero after the initial clear.
        sweep();
        chk("sweep_last_d_out", 0, d_out_w[0], 32'd0);

        // Byte-enabled merge, then be=0 no-op.
        op(1, 0, 4'd5, 32'hDEADBEEF, 4'b1111);
        op(1, 0, 4'd5, 32'h11223344, 4'b0101);
        op(0, 1, 4'd5, 32'h0, 4'b0);
        chk("merge_d_out", 0, d_out_w[0], 32'hDE22BE44);
        chk("merge_rd_valid", 0, 32'(rv_w[0]), 32'd1);
        op(1, 0, 4'd5, 32'hFFFFFFFF, 4'b0000);
        op(0, 1, 4'd5, 32'h0, 4'b0);
        chk("be0_noop_d_out", 0, d_out_w[0], 32'hDE22BE44);

        // Read-before-write on the same address.
        op(1, 1, 4'd3, 32'hA5A5A5A5, 4'b1111);
        chk("rbw_old_data", 0, d_out_w[0], 32'h0);
        op(0, 1, 4'd3, 32'h0, 4'b0);
        chk("rbw_new_data", 0, d_out_w[0], 32'hA5A5A5A5);

        // Address 13 is out of range only for the DEPTH=12 instance.
        op(1, 0, 4'd13, 32'hCAFEF00D, 4'b1111);
        chk("oor_wr_addr_err", 1, 32'(ae_w[1]), 32'd1);
        chk("inr_wr_addr_err", 0, 32'(ae_w[0]), 32'd0);
        op(0, 1, 4'd13, 32'h0, 4'b0);
        chk("oor_rd_addr_err", 1, 32'(ae_w[1]), 32'd1);
        chk("oor_rd_valid", 1, 32'(rv_w[1]), 32'd1);
        chk("oor_rd_d_out", 1, d_out_w[1], 32'd0);
        chk("inr_rd_d_out", 0, d_out_w[0], 32'hCAFEF00D);
        sweep();

        // clr with en_wr held until the DEPTH=16 clear finishes; DEPTH=12 goes idle 4 edges earlier.
        @(negedge clk);
        clr = 1'b1; en_wr = 1'b1; addr = 4'd7; d_in = 32'h77777777; be = 4'b1111;
        @(negedge clk);
        clr = 1'b0;
        repeat (16) @(negedge clk);
        en_wr = 1'b0;
        chk("clr_done_busy", 0, 32'(busy_w[0]), 32'd0);
        op(0, 1, 4'd7, 32'h0, 4'b0);
        chk("clr_write_ignored", 0, d_out_w[0], 32'h0);
        chk("clr_short_then_write", 1, d_out_w[1], 32'h77777777);
        op(0, 1, 4'd5, 32'h0, 4'b0);
        chk("clr_wiped", 0, d_out_w[0], 32'h0);
        sweep();

        // Reset pulsed mid-clear restarts the full busy count; read on the clr edge is ignored.
        @(negedge clk);
        clr = 1'b1; en_rd = 1'b1; addr = 4'd5;
        @(negedge clk);
        clr = 1'b0; en_rd = 1'b0;
        chk("clr_edge_read_ignored", 0, 32'(rv_w[0]), 32'd0);
        repeat (5) @(negedge clk);
        #2 rst = 1'b0;
        busy_count(16, 12);

`ifdef MEM_RAM_PARITY_EN
        op(1, 0, 4'd2, 32'h000000FF, 4'b1111);
        @(negedge clk);
        u16.inject_flip(4'd2, 5'd0);
        m_mem[0][2][0] = ~m_mem[0][2][0];
        m_bad[0][2][0] = 1'b1;
        op(0, 1, 4'd2, 32'h0, 4'b0);
        chk("parity_flagged", 0, 32'(pe_w[0]), 32'd1);
        chk("parity_d_out", 0, d_out_w[0], 32'h000000FE);
        op(0, 1, 4'd4, 32'h0, 4'b0);
        chk("parity_clean", 0, 32'(pe_w[0]), 32'd0);
`endif

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_ram_param.md
Name: mem_ram_param

Overview:
Parametrised single-port synchronous RAM; next generation of the team's 16x32 memory block.
- Width and depth are generic.
- Per-byte write enables.
- Registered read with a valid strobe.
- Hardware clear sequencer replaces the old combinational reset loop.
- Out-of-range address detection.
Sits behind bus/test agents as a generic storage slave.

Parameters:
DATA_W, 32, data word width in bits; must be a multiple of 8
DEPTH, 16, number of words; need not be a power of two (minimum 2)
ADDR_W, $clog2(DEPTH), address width; derived, not overridden
BE_W, DATA_W/8, number of byte-enable bits; derived

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  asynchronous active-low reset
clr  input  1  synchronous request to re-run the clear sequence
en_wr  input  1  write request
en_rd  input  1  read request
addr  input  ADDR_W  word address
d_in  input  DATA_W  write data
be  input  BE_W  byte enables for writes; be[i] gates d_in[8i+7:8i]
d_out  output  DATA_W  registered read data
rd_valid  output  1  one-cycle pulse: d_out updated by a read
busy  output  1  clear sequence in progress; requests ignored
addr_err  output  1  one-cycle pulse: accepted request had addr >= DEPTH
par_err  output  1  one-cycle pulse with rd_valid: parity mismatch (see Optional Feature)

Behaviour:
- Reset (rst=0, async): FSM enters CLEAR with clear pointer 0.
  - Register resets: d_out=0, rd_valid=0, addr_err=0, par_err=0, busy=1.
  - Array contents are not reset directly.
- FSM states: CLEAR, IDLE.
- CLEAR:
  - Each cycle writes all-zero (with correct parity) to mem[ptr], then ptr++.
  - After writing DEPTH-1, go to IDLE next cycle.
  - busy=1 throughout; it drops on the first IDLE cycle. Total busy = DEPTH cycles after rst release.
  - en_wr/en_rd are ignored while busy: no write, rd_valid=0, addr_err=0.
- IDLE:
  - clr=1 moves to CLEAR with ptr=0 on the next edge.
  - A request on the same edge as clr is ignored.
  - busy rises the cycle after clr is sampled.
- Write (IDLE, en_wr=1, addr<DEPTH): for each i with be[i]=1, mem[addr] byte i <= d_in byte i. Other bytes keep their value. be=0 is a legal no-op.
- Read (IDLE, en_rd=1, addr<DEPTH): latency 1.
  - d_out <= mem[addr] and rd_valid=1 in the following cycle.
  - d_out holds its last value when no read occurs; it never goes X.
- Simultaneous en_wr and en_rd are both performed.
  - Same address: read returns the old (pre-write) data (read-before-write).
  - The written data is visible to the next read.
- Out of range (addr >= DEPTH, only possible when DEPTH is not a power of two):
  - Write is dropped.
  - Read gives rd_valid=1 and d_out=0.
  - addr_err pulses 1 cycle after the request.
- Back-to-back reads every cycle: rd_valid stays high continuously.
- Reset mid-CLEAR or mid-operation: returns immediately to the reset state; the clear sequence restarts from 0.

Optional Feature:
Macro MEM_RAM_PARITY_EN.
- Defined:
  - Each byte stores one extra even-parity bit, computed on write and on clear.
  - On each read, parity is recomputed over the stored bytes. par_err=1 alongside rd_valid if any byte mismatches.
  - Out-of-range reads never flag par_err.
  - Adds a hierarchical-access-only test hook: task/array bit flip for error injection.
- Undefined: no parity storage; par_err tied to 0.

Test Plan:
1. Release rst with DEPTH=16 -> busy=1 for exactly 16 cycles. Read all addresses afterwards -> d_out=0, rd_valid each cycle.
2. Write addr=5, d_in=32'hDEADBEEF, be=4'b1111; then write addr=5, d_in=32'h11223344, be=4'b0101; read addr 5 -> d_out=32'hDE22BE44 one cycle later.
3. Same cycle: en_wr=1 and en_rd=1, addr=3, d_in=32'hA5A5A5A5, old mem[3]=0 -> d_out=0. Next read of addr 3 -> 32'hA5A5A5A5.
4. DEPTH=12: write addr=13 then read addr=13 -> addr_err pulses both times, d_out=0, rd_valid=1, array unchanged.
5. Assert clr while holding en_wr -> writes ignored during busy, all locations 0 afterwards. Pulse rst low mid-clear -> busy restarts a full DEPTH-cycle count.
6. (MEM_RAM_PARITY_EN) Write 32'h000000FF to addr 2, flip bit 0 via hook, read addr 2 -> par_err=1 with rd_valid. Read an unmodified address -> par_err=0.
